bch15_syndrome_calc: RTL and testbench

- Syndrome calculator for the binary BCH(15,7), t=2 decoder over GF(2^4).
- Each clock it evaluates the 15-bit received word r(x) at α, α², α³.
- It registers the three 4-bit syndromes for the downstream key-equation / Chien-search stages.
- All-zero syndromes mean r(x) is a valid codeword.

---
 rtl/bch15_syndrome_calc.sv | 76 +++++++
 tb/tb_bch15_syndrome_calc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bch15_syndrome_calc.sv
// Syndrome calculator for the binary BCH(15,7) t=2 code over GF(2^4), p(x)=x^4+x+1.
// Evaluates r(x) at alpha, alpha^2, alpha^3 each cycle and registers the results (1-cycle latency).
module bch15_syndrome_calc (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] codeword,
    output logic [3:0]  S1,
    output logic [3:0]  S2,
    output logic [3:0]  S3
);

    localparam int unsigned N = 15;

    // Polynomial-basis value of alpha^e (b3..b0), exponent reduced mod 15.
    function automatic logic [3:0] alpha_pow(input int unsigned e);
        logic [3:0] v;
        v = 4'b0001;
        case (e % N)
            0:  v = 4'b0001;
            1:  v = 4'b0010;
            2:  v = 4'b0100;
            3:  v = 4'b1000;
            4:  v = 4'b0011;
            5:  v = 4'b0110;
            6:  v = 4'b1100;
            7:  v = 4'b1011;
            8:  v = 4'b0101;
            9:  v = 4'b1010;
            10: v = 4'b0111;
            11: v = 4'b1110;
            12: v = 4'b1111;
            13: v = 4'b1101;
            14: v = 4'b1001;
            default: v = 4'b0001;
        endcase
        return v;
    endfunction

    // Constant-exponent evaluation: every bit position gates one fixed column.
    function automatic logic [3:0] eval_at(input logic [14:0] r, input int unsigned k);
        logic [3:0] acc;
        acc = 4'b0000;
        for (int unsigned i = 0; i < N; i++) begin
            if (r[i]) acc = acc ^ alpha_pow(k * i);
        end
        return acc;
    endfunction

    logic [3:0] s1_d, s2_d, s3_d;
    logic [3:0] s1_q, s2_q, s3_q;

    // NOTE: every always_comb output gets a value on all paths so no latch is inferred.
    always_comb begin
        s1_d = eval_at(codeword, 1);
        s2_d = eval_at(codeword, 2);
        s3_d = eval_at(codeword, 3);
    end

    // NOTE: sequential state uses non-blocking assignments so all three registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 4'b0000;
            s2_q <= 4'b0000;
            s3_q <= 4'b0000;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign S1 = s1_q;
    assign S2 = s2_q;
    assign S3 = s3_q;

endmodule

// File: tb/tb_bch15_syndrome_calc.sv
// Scoreboard bench for bch15_syndrome_calc: expected syndromes queued at drive time, popped one edge later.
module tb_bch15_syndrome_calc;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
    } synd_t;

    logic        clk;
    logic        rst;
    logic [14:0] codeword;
    logic [3:0]  S1, S2, S3;

    int errors = 0;
    int checks = 0;
    synd_t sb[$];

    bch15_syndrome_calc dut (
        .clk      (clk),
        .rst      (rst),
        .codeword (codeword),
        .S1       (S1),
        .S2       (S2),
        .S3       (S3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic built from multiply-by-alpha shifts, not a lookup table.
    function automatic logic [3:0] mul_alpha(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] ref_pow(input int unsigned e);
        logic [3:0] v = 4'b0001;
        for (int unsigned j = 0; j < e % 15; j++) v = mul_alpha(v);
        return v;
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = 4'b0000;
        logic [3:0] x = a;
        for (int j = 0; j < 4; j++) begin
            if (b[j]) p = p ^ x;
            x = mul_alpha(x);
        end
        return p;
    endfunction

    function automatic synd_t ref_synd(input logic [14:0] r);
        synd_t s = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (r[i]) begin
                s.s1 = s.s1 ^ ref_pow(i);
                s.s2 = s.s2 ^ ref_pow(2 * i);
                s.s3 = s.s3 ^ ref_pow(3 * i);
            end
        end
        return s;
    endfunction

    task automatic apply(input logic [14:0] w, input synd_t exp, input string tag);
        synd_t e;
        @(negedge clk);
        codeword = w;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check(tag, {S1, S2, S3}, e);
        end
        check({tag, "_sq"}, S2, gf_mul(S1, S1));
    endtask

    initial begin
        logic [14:0] w;
        synd_t hold;

        rst = 1'b1;
        codeword = 15'd0;
        #1;
        check("reset_no_clock", {S1, S2, S3}, 12'h000);
        @(posedge clk);
        #1;
        check("reset_held", {S1, S2, S3}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        apply(15'd0, '0, "release_zero");

        apply(15'b101010111100101, '{4'b0000, 4'b0000, 4'b0000}, "valid_cw");
        apply(15'b101110011100101, '{4'b1011, 4'b1001, 4'b0010}, "double_err");
        apply(15'b010110111100101, '{4'b0101, 4'b0010, 4'b0001}, "burst_err");
        apply(15'd1, '{4'b0001, 4'b0001, 4'b0001}, "bit0_const");
        apply(15'd2, '{4'b0010, 4'b0100, 4'b1000}, "bit1_const");

        for (int i = 0; i < 15; i++) begin
            w = 15'd1 << i;
            apply(w, ref_synd(w), $sformatf("sweep_%0d", i));
        end

        // Input change between edges must not reach the registered outputs.
        apply(15'h1234, ref_synd(15'h1234), "hold_pre");
        hold = ref_synd(15'h1234);
        codeword = 15'h7ABC;
        #2;
        check("hold_between_edges", {S1, S2, S3}, hold);

        // Asynchronous reset mid-cycle, then reload on the first edge after release.
        rst = 1'b1;
        #1;
        check("async_reset", {S1, S2, S3}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        apply(15'h0F0F, ref_synd(15'h0F0F), "post_release");

        for (int n = 0; n < 200; n++) begin
            w = 15'($urandom);
            apply(w, ref_synd(w), $sformatf("rand_%0d", n));
        end

        // Linearity: syndrome of r^e equals the XOR of the individual syndromes.
        for (int n = 0; n < 4; n++) begin
            logic [14:0] r, e;
            r = 15'($urandom);
            e = 15'($urandom);
            apply(r ^ e, ref_synd(r) ^ ref_synd(e), $sformatf("linear_%0d", n));
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
